// File: rtl/cdc_fifo_gray_src_multi.sv
// Source half of a multi-channel gray-pointer CDC FIFO with a drain/isolate mode.
// Each channel owns a small storage array, a binary write pointer mirrored as a
// registered gray pointer, and a synchroniser for the destination's gray read
// pointer. A single isolate FSM blocks intake for all channels and reports when
// every in-flight beat has been consumed.
module cdc_fifo_gray_src_multi #(
  parameter int NumChan    = 5,
  parameter int DataWidth  = 32,
  parameter int LogDepth   = 1,
  parameter int SyncStages = 2
) (
  input  logic                                      src_clk_i,
  input  logic                                      src_rst_i,
  input  logic [NumChan*DataWidth-1:0]              src_data_i,
  input  logic [NumChan-1:0]                        src_valid_i,
  output logic [NumChan-1:0]                        src_ready_o,
  input  logic                                      isolate_i,
  output logic                                      isolated_o,
  output logic [NumChan*(LogDepth+1)-1:0]           fill_o,
  output logic [NumChan*(2**LogDepth)*DataWidth-1:0] async_data_o,
  output logic [NumChan*(LogDepth+1)-1:0]           async_wptr_o,
  input  logic [NumChan*(LogDepth+1)-1:0]           async_rptr_i
);

  localparam int PtrW  = LogDepth + 1;
  localparam int Depth = 2 ** LogDepth;
  // Full when the pointers differ only in their MSB.
  localparam logic [PtrW-1:0] MsbFlip = PtrW'(1) << LogDepth;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    ISOLATED
  } state_t;

  state_t              state_q, state_d;
  logic                isolated_q;
  logic [NumChan-1:0]  empty;

  function automatic logic [PtrW-1:0] gray2bin(input logic [PtrW-1:0] g);
    logic [PtrW-1:0] b;
    b[PtrW-1] = g[PtrW-1];
    for (int i = PtrW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    logic [PtrW-1:0]      wbin, wbin_next, wptr_q, rbin, fill;
    logic [PtrW-1:0]      sync_q [SyncStages];
    logic [DataWidth-1:0] mem    [Depth];
    logic                 full, push;

    assign rbin      = gray2bin(sync_q[SyncStages-1]);
    assign full      = (wbin == (rbin ^ MsbFlip));
    assign fill      = wbin - rbin;
    assign wbin_next = wbin + PtrW'(1);
    assign empty[c]  = (fill == '0);

    // Intake gate: isolate_i acts combinationally, the FSM on the following edges.
    assign src_ready_o[c] = !src_rst_i && !full && (state_q == RUN) && !isolate_i;
    assign push           = src_valid_i[c] && src_ready_o[c];

    // Pointer, synchroniser and storage registers for this channel.
    always_ff @(posedge src_clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (src_rst_i) begin
        wbin   <= '0;
        wptr_q <= '0;
        for (int i = 0; i < SyncStages; i++) sync_q[i] <= '0;
        // NOTE: storage is reset on purpose -- async_data_o must read all-zero after reset.
        for (int s = 0; s < Depth; s++) mem[s] <= '0;
      end else begin
        sync_q[0] <= async_rptr_i[c*PtrW +: PtrW];
        for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
        if (push) begin
          mem[wbin[LogDepth-1:0]] <= src_data_i[c*DataWidth +: DataWidth];
          wbin                    <= wbin_next;
          wptr_q                  <= wbin_next ^ (wbin_next >> 1);
        end
      end
    end

    assign async_wptr_o[c*PtrW +: PtrW] = wptr_q;
    assign fill_o[c*PtrW +: PtrW]       = fill;

    for (genvar s = 0; s < Depth; s++) begin : g_slot
      assign async_data_o[(c*Depth+s)*DataWidth +: DataWidth] = mem[s];
    end
  end

  // Isolate FSM next-state logic shared by all channels.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      RUN:      if (isolate_i) state_d = DRAIN;
      DRAIN: begin
        if (!isolate_i)  state_d = RUN;
        else if (&empty) state_d = ISOLATED;
      end
      ISOLATED: if (!isolate_i) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // FSM state register and its registered isolated flag.
  always_ff @(posedge src_clk_i) begin
    if (src_rst_i) begin
      state_q    <= RUN;
      isolated_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      isolated_q <= (state_d == ISOLATED);
    end
  end

  assign isolated_o = isolated_q;

endmodule

// File: tb/tb_cdc_fifo_gray_src_multi.sv
// Bench for cdc_fifo_gray_src_multi: a directed vector table walking the
// documented scenarios, then randomized traffic against a queue-level model.
module tb_cdc_fifo_gray_src_multi;

  localparam int NC  = 2;
  localparam int DW  = 8;
  localparam int LD  = 1;
  localparam int SS  = 2;
  localparam int PW  = LD + 1;
  localparam int DEP = 2 ** LD;
  localparam int NRAND = 500;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  iso;
  logic [NC*DW-1:0]      data;
  logic [NC-1:0]         valid;
  logic [NC-1:0]         ready;
  logic                  isolated;
  logic [NC*PW-1:0]      fill;
  logic [NC*DEP*DW-1:0]  adata;
  logic [NC*PW-1:0]      wptr;
  logic [NC*PW-1:0]      rptr;

  cdc_fifo_gray_src_multi #(
    .NumChan(NC), .DataWidth(DW), .LogDepth(LD), .SyncStages(SS)
  ) dut (
    .src_clk_i   (clk),
    .src_rst_i   (rst),
    .src_data_i  (data),
    .src_valid_i (valid),
    .src_ready_o (ready),
    .isolate_i   (iso),
    .isolated_o  (isolated),
    .fill_o      (fill),
    .async_data_o(adata),
    .async_wptr_o(wptr),
    .async_rptr_i(rptr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  // exp_ready is the combinational ready seen with this row's inputs before the
  // edge; the remaining expectations are observed just after the edge.
  typedef struct {
    logic        rst;
    logic        iso;
    logic [1:0]  valid;
    logic [15:0] data;
    logic [3:0]  rptr;
    logic [1:0]  exp_ready;
    logic [3:0]  exp_fill;
    logic [3:0]  exp_wptr;
    logic        exp_iso;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t tbl[25];

  // ---------------- reference model ----------------
  int              wcnt[NC];       // beats ever accepted per channel
  int              rcnt[NC];       // beats consumed by the modelled destination
  logic [PW-1:0]   seen[NC][SS];   // read pointer values in flight through the synchroniser
  logic [DW-1:0]   mmem[NC][DEP];
  logic [DW-1:0]   beats[NC][1024];
  int              mstate;         // 0 run, 1 drain, 2 isolated
  logic            miso;

  function automatic logic [PW-1:0] to_gray(input int n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  function automatic int from_gray(input logic [PW-1:0] g);
    int b;
    b = 0;
    for (int i = 0; i < PW; i++) b = b ^ (int'(g) >> i);
    return b;
  endfunction

  function automatic int m_fill(input int c);
    return (wcnt[c] - from_gray(seen[c][SS-1])) & ((1 << PW) - 1);
  endfunction

  function automatic logic m_ready(input int c);
    return !rst && (m_fill(c) != DEP) && (mstate == 0) && !iso;
  endfunction

  task automatic model_reset();
    mstate = 0;
    miso   = 1'b0;
    for (int c = 0; c < NC; c++) begin
      wcnt[c] = 0;
      rcnt[c] = 0;
      for (int i = 0; i < SS; i++) seen[c][i] = '0;
      for (int s = 0; s < DEP; s++) mmem[c][s] = '0;
    end
  endtask

  // Apply one rising edge to the model using the inputs present at that edge.
  task automatic model_step();
    logic rdy[NC];
    logic all_empty;
    all_empty = 1'b1;
    for (int c = 0; c < NC; c++) begin
      rdy[c] = m_ready(c);
      if (m_fill(c) != 0) all_empty = 1'b0;
    end
    if (rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < NC; c++) begin
        if (valid[c] && rdy[c]) begin
          mmem[c][wcnt[c] % DEP] = data[c*DW +: DW];
          beats[c][wcnt[c]]      = data[c*DW +: DW];
          wcnt[c]++;
        end
        for (int i = SS - 1; i > 0; i--) seen[c][i] = seen[c][i-1];
        seen[c][0] = rptr[c*PW +: PW];
      end
      case (mstate)
        0: if (iso) mstate = 1;
        1: if (!iso) mstate = 0; else if (all_empty) mstate = 2;
        default: if (!iso) mstate = 0;
      endcase
      miso = (mstate == 2);
    end
  endtask

  task automatic check_model_outputs();
    logic [NC*PW-1:0]     ef, ew;
    logic [NC*DEP*DW-1:0] em;
    for (int c = 0; c < NC; c++) begin
      ef[c*PW +: PW] = PW'(m_fill(c));
      ew[c*PW +: PW] = to_gray(wcnt[c]);
      for (int s = 0; s < DEP; s++) em[(c*DEP+s)*DW +: DW] = mmem[c][s];
    end
    check("rand_fill", 64'(fill), 64'(ef));
    check("rand_wptr", 64'(wptr), 64'(ew));
    check("rand_isolated", 64'(isolated), 64'(miso));
    check("rand_data", 64'(adata), 64'(em));
  endtask

  initial begin
    rst = 1'b1; iso = 1'b0; valid = '0; data = '0; rptr = '0;

    //          rst   iso   valid  data      rptr   rdy    fill   wptr   iso   mem
    tbl[0]  = '{1'b1, 1'b0, 2'b00, 16'h0000, 4'h0, 2'b00, 4'h0, 4'h0, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b1, 1'b0, 2'b00, 16'h0000, 4'h0, 2'b00, 4'h0, 4'h0, 1'b0, 32'h0000_0000};
    tbl[2]  = '{1'b1, 1'b0, 2'b00, 16'h0000, 4'h0, 2'b00, 4'h0, 4'h0, 1'b0, 32'h0000_0000};
    tbl[3]  = '{1'b0, 1'b0, 2'b00, 16'h0000, 4'h0, 2'b11, 4'h0, 4'h0, 1'b0, 32'h0000_0000};
    tbl[4]  = '{1'b0, 1'b0, 2'b01, 16'h00A1, 4'h0, 2'b11, 4'h1, 4'h1, 1'b0, 32'h0000_00A1};
    tbl[5]  = '{1'b0, 1'b0, 2'b01, 16'h00A2, 4'h0, 2'b11, 4'h2, 4'h3, 1'b0, 32'h0000_A2A1};
    tbl[6]  = '{1'b0, 1'b0, 2'b00, 16'h0000, 4'h0, 2'b10, 4'h2, 4'h3, 1'b0, 32'h0000_A2A1};
    tbl[7]  = '{1'b0, 1'b0, 2'b00, 16'h0000, 4'h1, 2'b10, 4'h2, 4'h3, 1'b0, 32'h0000_A2A1};
    tbl[8]  = '{1'b0, 1'b0, 2'b00, 16'h0000, 4'h3, 2'b10, 4'h1, 4'h3, 1'b0, 32'h0000_A2A1};
    tbl[9]  = '{1'b0, 1'b0, 2'b00, 16'h0000, 4'h3, 2'b11, 4'h0, 4'h3, 1'b0, 32'h0000_A2A1};
    tbl[10] = '{1'b0, 1'b0, 2'b01, 16'h00A3, 4'h3, 2'b11, 4'h1, 4'h2, 1'b0, 32'h0000_A2A3};
    tbl[11] = '{1'b0, 1'b0, 2'b11, 16'hB1A4, 4'h2, 2'b11, 4'h6, 4'h4, 1'b0, 32'h00B1_A4A3};
    tbl[12] = '{1'b0, 1'b0, 2'b00, 16'h0000, 4'h2, 2'b10, 4'h5, 4'h4, 1'b0, 32'h00B1_A4A3};
    tbl[13] = '{1'b0, 1'b1, 2'b00, 16'h0000, 4'h2, 2'b00, 4'h5, 4'h4, 1'b0, 32'h00B1_A4A3};
    tbl[14] = '{1'b0, 1'b1, 2'b00, 16'h0000, 4'h4, 2'b00, 4'h5, 4'h4, 1'b0, 32'h00B1_A4A3};
    tbl[15] = '{1'b0, 1'b1, 2'b00, 16'h0000, 4'h4, 2'b00, 4'h0, 4'h4, 1'b0, 32'h00B1_A4A3};
    tbl[16] = '{1'b0, 1'b1, 2'b00, 16'h0000, 4'h4, 2'b00, 4'h0, 4'h4, 1'b1, 32'h00B1_A4A3};
    tbl[17] = '{1'b0, 1'b1, 2'b00, 16'h0000, 4'h4, 2'b00, 4'h0, 4'h4, 1'b1, 32'h00B1_A4A3};
    tbl[18] = '{1'b0, 1'b0, 2'b00, 16'h0000, 4'h4, 2'b00, 4'h0, 4'h4, 1'b0, 32'h00B1_A4A3};
    tbl[19] = '{1'b0, 1'b0, 2'b00, 16'h0000, 4'h4, 2'b11, 4'h0, 4'h4, 1'b0, 32'h00B1_A4A3};
    tbl[20] = '{1'b0, 1'b0, 2'b11, 16'hB2A5, 4'h4, 2'b11, 4'h5, 4'hD, 1'b0, 32'hB2B1_A4A5};
    tbl[21] = '{1'b0, 1'b0, 2'b11, 16'hB3A6, 4'h4, 2'b11, 4'hA, 4'hB, 1'b0, 32'hB2B3_A6A5};
    tbl[22] = '{1'b0, 1'b0, 2'b00, 16'h0000, 4'h4, 2'b00, 4'hA, 4'hB, 1'b0, 32'hB2B3_A6A5};
    tbl[23] = '{1'b1, 1'b0, 2'b00, 16'h0000, 4'h0, 2'b00, 4'h0, 4'h0, 1'b0, 32'h0000_0000};
    tbl[24] = '{1'b0, 1'b0, 2'b00, 16'h0000, 4'h0, 2'b11, 4'h0, 4'h0, 1'b0, 32'h0000_0000};

    for (int r = 0; r < 25; r++) begin
      @(negedge clk);
      rst = tbl[r].rst; iso = tbl[r].iso; valid = tbl[r].valid;
      data = tbl[r].data; rptr = tbl[r].rptr;
      #1;
      check($sformatf("vec%0d_ready", r), 64'(ready), 64'(tbl[r].exp_ready));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_fill", r), 64'(fill), 64'(tbl[r].exp_fill));
      check($sformatf("vec%0d_wptr", r), 64'(wptr), 64'(tbl[r].exp_wptr));
      check($sformatf("vec%0d_isolated", r), 64'(isolated), 64'(tbl[r].exp_iso));
      check($sformatf("vec%0d_data", r), 64'(adata), 64'(tbl[r].exp_mem));
    end

    // ---------------- randomized traffic against the model ----------------
    model_reset();
    @(negedge clk);
    rst = 1'b1; iso = 1'b0; valid = '0; rptr = '0;
    repeat (2) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    rst = 1'b0;

    for (int n = 0; n < NRAND; n++) begin
      logic [NC-1:0] er;
      // Destination side: consume a written beat now and then, checking its payload.
      for (int c = 0; c < NC; c++) begin
        if (rcnt[c] < wcnt[c] && $urandom_range(0, 2) != 0) begin
          check($sformatf("rand_pop_ch%0d", c),
                64'(adata[(c*DEP + rcnt[c] % DEP)*DW +: DW]), 64'(beats[c][rcnt[c]]));
          rcnt[c]++;
        end
        rptr[c*PW +: PW] = to_gray(rcnt[c]);
      end
      valid = NC'($urandom);
      data  = (NC*DW)'($urandom);
      if ($urandom_range(0, 15) == 0) iso = ~iso;
      #1;
      for (int c = 0; c < NC; c++) er[c] = m_ready(c);
      check("rand_ready", 64'(ready), 64'(er));
      @(posedge clk);
      model_step();
      #1;
      check_model_outputs();
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
